// File: rtl/audio_pwm_stage_if.sv
// rtl/audio_pwm_stage_if.sv - sample/control/PWM bundle for audio_pwm_stage
//
// Purpose: groups the sample stream, gain controls and PWM/status outputs.
// Signals:
//   sample_ena  one-cycle strobe, new samples valid on audio
//   audio       CHANNELS*SAMPLE_W packed signed samples, channel 0 in LSBs
//   volume      CHANNELS*GAIN_W packed target gains
//   mute        ramp all gains to 0
//   active      stream active; 0 forces outputs low and gains to 0
//   pwm         per-channel PWM outputs
//   period_tick one-cycle pulse at PWM counter wrap
//   busy        multiplier sequencer running
//   overrun     sticky: sample_ena arrived while busy
// Modports: master drives the stream/controls, slave is the stage.
interface audio_pwm_stage_if #(
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 16,
    parameter int GAIN_W   = 16
);
    logic                         sample_ena;
    logic [CHANNELS*SAMPLE_W-1:0] audio;
    logic [CHANNELS*GAIN_W-1:0]   volume;
    logic                         mute;
    logic                         active;
    logic [CHANNELS-1:0]          pwm;
    logic                         period_tick;
    logic                         busy;
    logic                         overrun;

    modport master (
        output sample_ena, audio, volume, mute, active,
        input  pwm, period_tick, busy, overrun
    );

    modport slave (
        input  sample_ena, audio, volume, mute, active,
        output pwm, period_tick, busy, overrun
    );
endinterface

// File: rtl/audio_pwm_stage.sv
// rtl/audio_pwm_stage.sv - ramped per-channel gain scaling and PWM output stage
//
// Purpose: scales each channel's sample by a ramped gain using one shared
// sign-magnitude multiplier, then quantises the result to a PWM duty that is
// reloaded once per PWM period.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   io_bus   audio_pwm_stage_if.slave (sample stream, controls, PWM, status)
// Optional feature macro: PWM_ERROR_FEEDBACK_EN
//   defined   - first-order error-feedback quantiser (per-channel residual
//               accumulator, duty saturates at all-ones)
//   undefined - plain truncation of the offset-binary result
module audio_pwm_stage #(
    parameter int                CHANNELS  = 2,
    parameter int                SAMPLE_W  = 16,
    parameter int                GAIN_W    = 16,
    parameter int                PWM_W     = 7,
    parameter logic [GAIN_W-1:0] RAMP_STEP = 16'h0400
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    audio_pwm_stage_if.slave  io_bus
);
    localparam int PROD_W = SAMPLE_W + GAIN_W;
    localparam int MAG_W  = SAMPLE_W + 1;  // holds |-2^(SAMPLE_W-1)| without wrap
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t                    r_state, w_state_nxt;
    logic [CH_W-1:0]           r_ch;
    logic [SAMPLE_W-1:0]       r_audio    [CHANNELS];
    logic [GAIN_W-1:0]         r_gain_cur [CHANNELS];
    logic [PROD_W-1:0]         r_prod;
    logic                      r_prod_neg;
    logic [CH_W-1:0]           r_prod_ch;
    logic                      r_prod_vld;
    logic signed [PROD_W-1:0]  r_scaled   [CHANNELS];
    logic [PWM_W-1:0]          r_duty     [CHANNELS];
    logic [PWM_W-1:0]          r_cnt;
    logic [CHANNELS-1:0]       r_pwm;
    logic                      r_overrun;

    logic                      w_accept;
    logic                      w_last_ch;
    logic                      w_tick;
    logic signed [SAMPLE_W-1:0] w_sample;
    logic [MAG_W-1:0]          w_mag;
    logic [PROD_W-1:0]         w_prod;
    logic [GAIN_W-1:0]         w_gain_nxt [CHANNELS];
    logic [PWM_W-1:0]          w_duty_nxt [CHANNELS];

    assign w_accept  = io_bus.sample_ena && (r_state == S_IDLE);
    assign w_last_ch = (r_ch == CH_W'(CHANNELS - 1));
    assign w_tick    = (r_cnt == {PWM_W{1'b1}});

    // Sign-magnitude multiply: the magnitude is one bit wider than the sample
    // so negative full scale stays exact; the product always fits PROD_W bits.
    assign w_sample = r_audio[r_ch];
    assign w_mag    = w_sample[SAMPLE_W-1] ? MAG_W'(-{w_sample[SAMPLE_W-1], w_sample})
                                           : {1'b0, w_sample};
    assign w_prod   = PROD_W'(w_mag) * PROD_W'(r_gain_cur[r_ch]);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (io_bus.sample_ena) w_state_nxt = S_MUL;
            S_MUL:   if (w_last_ch) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [GAIN_W-1:0] w_target;
        logic [GAIN_W-1:0] w_diff;
        logic              w_up;

        // Ramp toward the target by at most RAMP_STEP, landing exactly on it.
        assign w_target = (io_bus.mute || !io_bus.active) ? '0
                                                          : io_bus.volume[g*GAIN_W +: GAIN_W];
        assign w_up     = (w_target > r_gain_cur[g]);
        assign w_diff   = w_up ? (w_target - r_gain_cur[g]) : (r_gain_cur[g] - w_target);
        assign w_gain_nxt[g] = (w_diff > RAMP_STEP)
                             ? (w_up ? r_gain_cur[g] + RAMP_STEP : r_gain_cur[g] - RAMP_STEP)
                             : w_target;

`ifdef PWM_ERROR_FEEDBACK_EN
        localparam int RES_W = PROD_W - PWM_W;
        logic [PROD_W-1:0] w_offset;
        logic [PROD_W:0]   w_sum;
        logic [RES_W-1:0]  r_acc;

        // Offset binary, plus the residual left over from the last period.
        assign w_offset      = {~r_scaled[g][PROD_W-1], r_scaled[g][PROD_W-2:0]};
        assign w_sum         = {1'b0, w_offset} + {{(PWM_W+1){1'b0}}, r_acc};
        assign w_duty_nxt[g] = w_sum[PROD_W] ? {PWM_W{1'b1}} : w_sum[PROD_W-1 -: PWM_W];

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_acc <= '0;
            end else if (w_tick) begin
                r_acc <= w_sum[RES_W-1:0];
            end
        end
`else
        // Offset binary is the scaled value with its sign bit inverted.
        assign w_duty_nxt[g] = {~r_scaled[g][PROD_W-1], r_scaled[g][PROD_W-2 -: PWM_W-1]};
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_ch       <= '0;
            r_prod     <= '0;
            r_prod_neg <= 1'b0;
            r_prod_ch  <= '0;
            r_prod_vld <= 1'b0;
            r_cnt      <= '0;
            r_pwm      <= '0;
            r_overrun  <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_audio[c]    <= '0;
                r_gain_cur[c] <= '0;
                r_scaled[c]   <= '0;
                r_duty[c]     <= {1'b1, {(PWM_W-1){1'b0}}};
            end
        end else begin
            r_state <= w_state_nxt;

            if (io_bus.sample_ena && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end

            if (w_accept) begin
                r_ch <= '0;
                for (int c = 0; c < CHANNELS; c++) begin
                    r_audio[c] <= io_bus.audio[c*SAMPLE_W +: SAMPLE_W];
                end
            end else if (r_state == S_MUL) begin
                r_ch <= r_ch + 1'b1;
            end

            for (int c = 0; c < CHANNELS; c++) begin
                if (!io_bus.active) begin
                    r_gain_cur[c] <= '0;
                end else if (w_accept) begin
                    r_gain_cur[c] <= w_gain_nxt[c];
                end
            end

            // Product stage, then sign reapplied one cycle later.
            r_prod_vld <= (r_state == S_MUL);
            if (r_state == S_MUL) begin
                r_prod     <= w_prod;
                r_prod_neg <= w_sample[SAMPLE_W-1];
                r_prod_ch  <= r_ch;
            end
            if (r_prod_vld) begin
                r_scaled[r_prod_ch] <= r_prod_neg ? PROD_W'(-r_prod) : r_prod;
            end

            // Duty reload on the wrap edge samples r_scaled before any
            // same-cycle update, so a coincident write waits a period.
            r_cnt <= r_cnt + 1'b1;
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_tick) begin
                    r_duty[c] <= w_duty_nxt[c];
                end
                r_pwm[c] <= io_bus.active && (r_cnt < r_duty[c]);
            end
        end
    end

    assign io_bus.pwm         = r_pwm;
    assign io_bus.period_tick = w_tick;
    assign io_bus.busy        = (r_state != S_IDLE);
    assign io_bus.overrun     = r_overrun;
endmodule

// File: tb/tb_audio_pwm_stage.sv
// tb/tb_audio_pwm_stage.sv - self-checking bench for audio_pwm_stage
module tb_audio_pwm_stage;
    localparam int CH = 2;
    localparam int SW = 16;
    localparam int GW = 16;
    localparam int PW = 7;

    typedef struct {
        logic [15:0] a0, a1;
        logic [31:0] s0, s1;
        logic [6:0]  d0, d1;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    int   mg [CH];          // reference gains
    vec_t vecs [4];

    audio_pwm_stage_if #(.CHANNELS(CH), .SAMPLE_W(SW), .GAIN_W(GW)) bus ();

    audio_pwm_stage #(.CHANNELS(CH), .SAMPLE_W(SW), .GAIN_W(GW), .PWM_W(PW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: signed product, offset-binary truncation, bounded ramp.
    function automatic logic [31:0] m_scaled(input logic [15:0] s, input int g);
        longint p;
        p = longint'($signed(s)) * longint'(g);
        return p[31:0];
    endfunction

    function automatic logic [6:0] m_duty(input logic [31:0] sc);
        logic [31:0] o;
        o = sc + 32'h8000_0000;
        return o[31:25];
    endfunction

    function automatic int m_ramp(input int g, input int t);
        if (t > g) return (t - g > 1024) ? g + 1024 : t;
        return (g - t > 1024) ? g - 1024 : t;
    endfunction

    task automatic strobe(input logic [15:0] a0, input logic [15:0] a1);
        @(negedge clk);
        bus.audio      = {a1, a0};
        bus.sample_ena = 1'b1;
        @(negedge clk);
        bus.sample_ena = 1'b0;
        for (int c = 0; c < CH; c++) begin
            if (!bus.active) mg[c] = 0;
            else mg[c] = m_ramp(mg[c], bus.mute ? 0 : int'(bus.volume[c*GW +: GW]));
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("busy_timeout", 32'(n >= 20), 0);
    endtask

    task automatic wait_load();
        int n;
        n = 0;
        while (!bus.period_tick && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("tick_timeout", 32'(n >= 300), 0);
        @(negedge clk);
    endtask

    task automatic count_pwm(output int h0, output int h1);
        h0 = 0;
        h1 = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            h0 += int'(bus.pwm[0]);
            h1 += int'(bus.pwm[1]);
        end
    endtask

    initial begin
        int h0, h1, bcnt;
        logic [15:0] ra0, ra1;
        logic [6:0]  hd0, hd1;

        n_pass  = 0;
        n_total = 0;
        mg[0] = 0;
        mg[1] = 0;
        vecs[0] = '{16'h7FFF, 16'h8000, 32'h7FFE8001, 32'h80008000, 7'd127, 7'd0};
        vecs[1] = '{16'h0000, 16'h0001, 32'h00000000, 32'h0000FFFF, 7'd64,  7'd64};
        vecs[2] = '{16'hC000, 16'h4000, 32'hC0004000, 32'h3FFFC000, 7'd32,  7'd95};
        vecs[3] = '{16'h0000, 16'hFFFF, 32'h00000000, 32'hFFFF0001, 7'd64,  7'd63};

        // Reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.sample_ena = 1'($urandom);
            bus.audio      = 32'($urandom);
            bus.volume     = 32'($urandom);
            bus.mute       = 1'($urandom);
            bus.active     = 1'($urandom);
            @(negedge clk);
        end
        chk("rst_pwm", 32'(bus.pwm), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_overrun", 32'(bus.overrun), 0);
        chk("rst_tick", 32'(bus.period_tick), 0);
        chk("rst_duty0", 32'(dut.r_duty[0]), 64);

        bus.sample_ena = 1'b0;
        bus.audio      = '0;
        bus.volume     = 32'hFFFF_FFFF;
        bus.mute       = 1'b0;
        bus.active     = 1'b1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        count_pwm(h0, h1);
        chk("idle_half_duty0", 32'(h0), 64);
        chk("idle_half_duty1", 32'(h1), 64);

        // Ramp up 0 -> FFFF
        for (int i = 0; i < 63; i++) begin
            strobe(16'h0, 16'h0);
            wait_idle();
        end
        chk("ramp63_g0", 32'(dut.r_gain_cur[0]), 32'hFC00);
        chk("ramp63_g1", 32'(dut.r_gain_cur[1]), 32'hFC00);
        strobe(16'h0, 16'h0);
        wait_idle();
        chk("ramp64_g0", 32'(dut.r_gain_cur[0]), 32'hFFFF);
        chk("ramp64_g1", 32'(dut.r_gain_cur[1]), 32'hFFFF);

        // Fixed vectors at full gain
        for (int v = 0; v < 4; v++) begin
            strobe(vecs[v].a0, vecs[v].a1);
            wait_idle();
            chk($sformatf("vec%0d_scaled0", v), dut.r_scaled[0], vecs[v].s0);
            chk($sformatf("vec%0d_scaled1", v), dut.r_scaled[1], vecs[v].s1);
            wait_load();
            chk($sformatf("vec%0d_duty0", v), 32'(dut.r_duty[0]), 32'(vecs[v].d0));
            chk($sformatf("vec%0d_duty1", v), 32'(dut.r_duty[1]), 32'(vecs[v].d1));
            count_pwm(h0, h1);
            chk($sformatf("vec%0d_pwm0", v), 32'(h0), 32'(vecs[v].d0));
            chk($sformatf("vec%0d_pwm1", v), 32'(h1), 32'(vecs[v].d1));
        end

        // Mute ramps back to 0 in 64 strobes
        bus.mute = 1'b1;
        for (int i = 0; i < 63; i++) begin
            strobe(16'h1234, 16'h4321);
            wait_idle();
        end
        chk("mute63_g0", 32'(dut.r_gain_cur[0]), 32'h03FF);
        strobe(16'h1234, 16'h4321);
        wait_idle();
        chk("mute64_g0", 32'(dut.r_gain_cur[0]), 0);
        chk("mute64_g1", 32'(dut.r_gain_cur[1]), 0);
        chk("mute64_scaled0", dut.r_scaled[0], 0);
        bus.mute = 1'b0;

        // Randomized against the reference model
        ra0 = '0;
        ra1 = '0;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: bus.volume = 32'hFFFF_FFFF;
                1: bus.volume = {16'($urandom_range(0, 65535)), 16'h0000};
                default: bus.volume = 32'($urandom);
            endcase
            bus.mute = ($urandom_range(0, 5) == 0);
            ra0 = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            ra1 = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
            strobe(ra0, ra1);
            wait_idle();
            chk($sformatf("rnd%0d_g0", i), 32'(dut.r_gain_cur[0]), 32'(mg[0]));
            chk($sformatf("rnd%0d_g1", i), 32'(dut.r_gain_cur[1]), 32'(mg[1]));
            chk($sformatf("rnd%0d_scaled0", i), dut.r_scaled[0], m_scaled(ra0, mg[0]));
            chk($sformatf("rnd%0d_scaled1", i), dut.r_scaled[1], m_scaled(ra1, mg[1]));
            wait_load();
            chk($sformatf("rnd%0d_duty0", i), 32'(dut.r_duty[0]), 32'(m_duty(m_scaled(ra0, mg[0]))));
            chk($sformatf("rnd%0d_duty1", i), 32'(dut.r_duty[1]), 32'(m_duty(m_scaled(ra1, mg[1]))));
        end
        bus.mute = 1'b0;

`ifndef PWM_ERROR_FEEDBACK_EN
        // Truncation only: duty holds on the following period
        hd0 = m_duty(m_scaled(ra0, mg[0]));
        hd1 = m_duty(m_scaled(ra1, mg[1]));
        wait_load();
        chk("hold_duty0", 32'(dut.r_duty[0]), 32'(hd0));
        chk("hold_duty1", 32'(dut.r_duty[1]), 32'(hd1));
`endif

        // Overrun: second strobe one cycle after the first
        chk("pre_overrun", 32'(bus.overrun), 0);
        @(negedge clk);
        bus.audio      = {16'h2000, 16'hE000};
        bus.sample_ena = 1'b1;
        for (int c = 0; c < CH; c++)
            mg[c] = m_ramp(mg[c], int'(bus.volume[c*GW +: GW]));
        bcnt = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bcnt += int'(bus.busy);
            if (k == 1) bus.audio = {16'h7777, 16'h1111};
            if (k == 2) bus.sample_ena = 1'b0;
        end
        chk("busy_cycles", 32'(bcnt), 3);
        chk("overrun_set", 32'(bus.overrun), 1);
        chk("ovr_scaled0", dut.r_scaled[0], m_scaled(16'hE000, mg[0]));
        chk("ovr_scaled1", dut.r_scaled[1], m_scaled(16'h2000, mg[1]));
        strobe(16'h0100, 16'h0200);
        wait_idle();
        chk("overrun_sticky", 32'(bus.overrun), 1);
        chk("post_ovr_scaled0", dut.r_scaled[0], m_scaled(16'h0100, mg[0]));

        // Active drop mid-period
        bus.volume = 32'hFFFF_FFFF;
        for (int i = 0; i < 64; i++) begin
            strobe(16'h7FFF, 16'h7FFF);
            wait_idle();
        end
        wait_load();
        repeat (10) @(negedge clk);
        chk("pre_drop_pwm0", 32'(bus.pwm[0]), 1);
        bus.active = 1'b0;
        @(negedge clk);
        chk("drop_pwm", 32'(bus.pwm), 0);
        chk("drop_g0", 32'(dut.r_gain_cur[0]), 0);
        chk("drop_g1", 32'(dut.r_gain_cur[1]), 0);
        mg[0] = 0;
        mg[1] = 0;
        bus.active = 1'b1;
        strobe(16'h7FFF, 16'h7FFF);
        wait_idle();
        chk("reactive_g0", 32'(dut.r_gain_cur[0]), 32'h0400);
        chk("reactive_scaled0", dut.r_scaled[0], m_scaled(16'h7FFF, 32'h0400));

        // Reset in the middle of a sequence
        @(negedge clk);
        bus.audio      = {16'h4000, 16'h4000};
        bus.sample_ena = 1'b1;
        @(negedge clk);
        bus.sample_ena = 1'b0;
        chk("mid_busy", 32'(bus.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_overrun", 32'(bus.overrun), 0);
        chk("arst_pwm", 32'(bus.pwm), 0);
        chk("arst_g0", 32'(dut.r_gain_cur[0]), 0);
        chk("arst_scaled0", dut.r_scaled[0], 0);
        chk("arst_duty1", 32'(dut.r_duty[1]), 64);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/audio_pwm_stage.md
# audio_pwm_stage

Multichannel output stage between the USB audio sample stream and the PWM audio pins. Per-channel sign-magnitude gain scaling uses one time-multiplexed multiplier. Gain changes and mute are ramped to avoid zipper noise, and each result is quantised to a PWM duty that is held for one full PWM period. It replaces the fixed two-channel scale/PWM logic in the amplifier top level with a parametrised block.

## Interface
- CHANNELS, 2, number of audio channels
- SAMPLE_W, 16, signed two's-complement sample width
- GAIN_W, 16, unsigned gain width, Q0.GAIN_W fraction (all-ones ≈ 1.0)
- PWM_W, 7, duty resolution; PWM period = 2^PWM_W clocks
- RAMP_STEP, 16'h0400, maximum gain change per sample strobe
- Clk  in  1  system clock (50 MHz)
- nReset  in  1  asynchronous, active-low reset
- Sample_Ena  in  1  one-cycle strobe: new samples valid on Audio
- Audio  in  CHANNELS*SAMPLE_W  packed samples, channel 0 in LSBs
- Volume  in  CHANNELS*GAIN_W  packed target gains (log-mapped upstream)
- Mute  in  1  ramp all gains to 0
- Active  in  1  stream active; 0 forces outputs low and gains to 0
- Pwm  out  CHANNELS  PWM outputs
- Period_Tick  out  1  one-cycle pulse at PWM counter wrap
- Busy  out  1  multiplier sequencer running
- Overrun  out  1  sticky: Sample_Ena arrived while Busy

## Operation
- Sequencer FSM states: IDLE, MUL, DONE.
  - IDLE → MUL on Sample_Ena. Latch Audio and step every channel's gain, then set ch=0.
  - MUL: one channel per cycle. Product = |sample| × Gain_Cur[ch], registered. The sign is reapplied the following cycle into Scaled[ch] (SAMPLE_W+GAIN_W bits, signed).
  - MUL → DONE after ch=CHANNELS−1. DONE → IDLE in 1 cycle.
- Sample_Ena while not IDLE: ignored, and Overrun is set. Only reset clears Overrun.
- Gain ramp, per Sample_Ena:
  - Target = (Mute | ~Active) ? 0 : Volume[ch].
  - Gain_Cur moves toward Target by min(RAMP_STEP, |Target−Gain_Cur|). It lands exactly on Target and never overshoots.
- Active=0 sets Gain_Cur to 0 immediately, without ramping.
- PWM counter: free-running PWM_W bits. Period_Tick pulses when the counter = 2^PWM_W−1.
- Duty update, on the cycle after Period_Tick for all channels:
  - Offset = {~Scaled[MSB], Scaled[MSB−1:0]}.
  - Duty = Offset[MSB:MSB−PWM_W+1].
- Pwm[ch] = Active & (count < Duty[ch]). Duty 0 gives constant low; the maximum duty is (2^PWM_W−1)/2^PWM_W.
- Negative full scale: magnitude of −2^(SAMPLE_W−1) is 2^(SAMPLE_W−1), held in SAMPLE_W+1 bits so it does not wrap.

## Timing
- Reset values:
  - Pwm = 0, Period_Tick = 0, Busy = 0, Overrun = 0.
  - Gain_Cur = 0, Scaled = 0, Duty = 2^(PWM_W−1), counter = 0, FSM = IDLE.
- Busy is high from the cycle after Sample_Ena for CHANNELS+1 cycles.
- Scaled[ch] is valid ch+2 cycles after Sample_Ena.
- A new sample reaches Pwm at the first period boundary after all Scaled values are valid. Worst-case latency is CHANNELS+2+2^PWM_W clocks.
- A Scaled update coincident with the duty-load cycle: duty loads the pre-update value.
- nReset asserted mid-sequence: all state returns to reset values asynchronously, and the partial sample is discarded.
- Mute toggled mid-ramp: the ramp reverses from the current Gain_Cur at the next Sample_Ena.

## Configuration
- PWM_ERROR_FEEDBACK_EN defined: a first-order error-feedback quantiser.
  - Residual low bits of Offset, below duty resolution, are accumulated per channel and added before truncation at the next period.
  - Duty saturates at 2^PWM_W−1.
  - The accumulator resets to 0.
- Not defined: plain truncation of Offset, with no accumulator registers.

## Test plan
- Reset: hold nReset=0 with random inputs -> Pwm=0, Busy=0, Overrun=0. After release with Active=1, Audio=0 and Volume=FFFF, Pwm is high 64 of every 128 clocks.
- Full scale: Gain_Cur=FFFF, Audio=7FFF -> Scaled=7FFE8001, duty 127. Audio=8000 -> Scaled=80008000, duty 0.
- Ramp: Volume 0→FFFF with Sample_Ena every 1042 clocks -> Gain_Cur=FC00 after 63 strobes and FFFF after 64. Mute=1 then returns it to 0 in 64 strobes.
- Overrun: second Sample_Ena 1 cycle after the first -> ignored, Overrun=1 sticky, and channel results match the first sample only.
- Active drop: Active=0 mid-period -> Pwm=0 next cycle and Gain_Cur=0. Re-assert -> gain ramps up from 0.
- Error feedback (macro defined): Offset constant with residual = ½ LSB -> duty alternates N and N+1 on successive periods. Without the macro -> constant N.
